// File: rtl/sdram_write_ctrl_if.sv
// Bus bundle between the SDRAM write controller and its surroundings
// (arbiter, refresh block, write FIFO and SDRAM pins).
interface sdram_write_ctrl_if;
  logic        wr_trig;
  logic        wr_req;
  logic        wr_en;
  logic        ref_req;
  logic        flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  bank_addr;
  logic [15:0] wr_data;
  logic        wr_dq_oe;
  logic        wfifo_rd_en;
  logic [7:0]  wfifo_rd_data;

  // controller side
  modport master (
    input  wr_trig, wr_en, ref_req, wfifo_rd_data,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr,
           wr_data, wr_dq_oe, wfifo_rd_en
  );

  // environment side
  modport slave (
    output wr_trig, wr_en, ref_req, wfifo_rd_data,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr,
           wr_data, wr_dq_oe, wfifo_rd_en
  );
endinterface

// File: rtl/sdram_write_ctrl.sv
// SDRAM write controller: on wr_trig, requests the bus, opens the current
// row and streams WR_BURSTS 4-word bursts from a FWFT FIFO. The job is
// suspended (PRE) at a burst boundary for refresh or at row end; the
// row/column position persists across jobs so successive jobs append.
module sdram_write_ctrl #(
  parameter logic [15:0] WR_BURSTS = 16'd256
) (
  input  logic              sclk,
  input  logic              reset,
  sdram_write_ctrl_if.master bus
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ACT  = 5'b00100,
    S_WR   = 5'b01000,
    S_PRE  = 5'b10000
  } state_t;

  state_t      state;
  logic [1:0]  tcnt;       // tRCD / tRP cycle counter
  logic [1:0]  burst_cnt;  // word index within a burst
  logic [15:0] burst_num;  // bursts completed in current job
  logic [6:0]  col_cnt;    // burst column (word column / 4)
  logic [11:0] row_addr;
  logic        flag_wr;    // job in progress

  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_dq_oe;
  logic        flag_wr_end;

  logic [15:0] burst_num_nxt;
  logic        burst_end, job_done, row_end, job_start;

  assign burst_num_nxt = burst_num + 16'd1;
  assign burst_end     = (state == S_WR) && (burst_cnt == 2'd3);
  assign job_done      = (burst_num_nxt == WR_BURSTS);
  assign row_end       = (col_cnt == 7'd127);
  assign job_start     = bus.wr_trig && !flag_wr;

  assign bus.wr_req      = (state == S_REQ);
  assign bus.wfifo_rd_en = (state == S_WR);
  assign bus.bank_addr   = 2'b00;
  assign bus.wr_cmd      = wr_cmd;
  assign bus.wr_addr     = wr_addr;
  assign bus.wr_data     = wr_data;
  assign bus.wr_dq_oe    = wr_dq_oe;
  assign bus.flag_wr_end = flag_wr_end;

  // Main FSM with registered SDRAM command/address/data outputs (one cycle behind state)
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tcnt        <= 2'd0;
      burst_cnt   <= 2'd0;
      wr_cmd      <= CMD_NOP;
      wr_addr     <= 12'd0;
      wr_data     <= 16'd0;
      wr_dq_oe    <= 1'b0;
      flag_wr_end <= 1'b0;
    end else begin
      wr_cmd      <= CMD_NOP;
      wr_dq_oe    <= 1'b0;
      flag_wr_end <= 1'b0;
      case (state)
        S_IDLE: if (bus.wr_trig) state <= S_REQ;
        S_REQ: begin
          if (bus.wr_en) begin
            state <= S_ACT;
            tcnt  <= 2'd0;
          end
        end
        S_ACT: begin
          if (tcnt == 2'd0) begin
            wr_cmd  <= CMD_ACT;
            wr_addr <= row_addr;
          end
          tcnt <= tcnt + 2'd1;
          if (tcnt == 2'd3) begin
            state     <= S_WR;
            burst_cnt <= 2'd0;
          end
        end
        S_WR: begin
          // FWFT: head word is valid in the pop cycle, driven on DQ next cycle
          wr_data  <= {8'h00, bus.wfifo_rd_data};
          wr_dq_oe <= 1'b1;
          if (burst_cnt == 2'd0) begin
            wr_cmd  <= CMD_WR;
            wr_addr <= {3'b000, col_cnt, 2'b00};
          end
          burst_cnt <= burst_cnt + 2'd1;
          // only leave at a burst boundary so no burst is truncated
          if (burst_cnt == 2'd3 && (job_done || bus.ref_req || row_end)) begin
            state <= S_PRE;
            tcnt  <= 2'd0;
          end
        end
        S_PRE: begin
          if (tcnt == 2'd0) begin
            wr_cmd  <= CMD_PRE;
            wr_addr <= 12'h400;   // A10 high: precharge all
          end
          tcnt <= tcnt + 2'd1;
          if (tcnt == 2'd3) begin
            if (!flag_wr) begin
              state       <= S_IDLE;
              flag_wr_end <= 1'b1;
            end else if (bus.ref_req) begin
              state       <= S_REQ;
              flag_wr_end <= 1'b1;
            end else begin
              // row crossing: keep the bus and open the next row
              state <= S_ACT;
              tcnt  <= 2'd0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Job flag, burst accounting and persistent row/column position
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      flag_wr   <= 1'b0;
      burst_num <= 16'd0;
      col_cnt   <= 7'd0;
      row_addr  <= 12'd0;
    end else begin
      if (job_start) begin
        flag_wr   <= 1'b1;
        burst_num <= 16'd0;
      end else if (burst_end) begin
        burst_num <= burst_num_nxt;
        if (job_done) flag_wr <= 1'b0;
      end
      if (burst_end) begin
        col_cnt <= col_cnt + 7'd1;
        if (row_end) row_addr <= row_addr + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_write_ctrl.sv
// Scoreboard bench: two controllers (2-burst jobs, and 129-burst jobs for
// the row crossing) share a FIFO model; expected commands and DQ words are
// queued when a job is set up and compared as the selected DUT emits them.
module tb_sdram_write_ctrl;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, ACT = 4'b0011, WRC = 4'b0100;

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] addr;
    int          gap;   // cycles since previous command, -1 = don't care
  } exp_cmd_t;

  logic sclk = 1'b0;
  logic reset;
  logic sel, trig_a, trig_b, wr_en, ref_req;
  logic [7:0] mem [0:1023];
  logic [9:0] rd_ptr = '0;
  logic [9:0] wr_ptr;

  exp_cmd_t    cmd_q[$];
  logic [15:0] data_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_cyc = 0, rd_cnt = 0, end_cnt = 0;

  always #5 sclk = ~sclk;

  sdram_write_ctrl_if ifa();
  sdram_write_ctrl_if ifb();

  sdram_write_ctrl #(.WR_BURSTS(16'd2))   dut    (.sclk(sclk), .reset(reset), .bus(ifa.master));
  sdram_write_ctrl #(.WR_BURSTS(16'd129)) dut_rc (.sclk(sclk), .reset(reset), .bus(ifb.master));

  assign ifa.wr_trig = trig_a;
  assign ifb.wr_trig = trig_b;
  assign ifa.wr_en   = wr_en;
  assign ifb.wr_en   = wr_en;
  assign ifa.ref_req = ref_req;
  assign ifb.ref_req = ref_req;
  assign ifa.wfifo_rd_data = mem[rd_ptr];
  assign ifb.wfifo_rd_data = mem[rd_ptr];

  logic [3:0]  m_cmd;
  logic [11:0] m_addr;
  logic [15:0] m_data;
  logic        m_oe, m_rden, m_end;
  assign m_cmd  = sel ? ifb.wr_cmd      : ifa.wr_cmd;
  assign m_addr = sel ? ifb.wr_addr     : ifa.wr_addr;
  assign m_data = sel ? ifb.wr_data     : ifa.wr_data;
  assign m_oe   = sel ? ifb.wr_dq_oe    : ifa.wr_dq_oe;
  assign m_rden = sel ? ifb.wfifo_rd_en : ifa.wfifo_rd_en;
  assign m_end  = sel ? ifb.flag_wr_end : ifa.flag_wr_end;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FWFT FIFO model: head advances on each pop
  always @(posedge sclk) if (m_rden) rd_ptr <= rd_ptr + 10'd1;

  // Output monitor: pops and compares against the scoreboard queues
  always @(negedge sclk) begin
    if (reset === 1'b1) begin
      cyc <= cyc + 1;
      if (m_rden) rd_cnt <= rd_cnt + 1;
      if (m_end)  end_cnt <= end_cnt + 1;
      if (m_cmd !== NOP) begin
        if (cmd_q.size() == 0) chk("unexpected_cmd", {m_cmd, m_addr}, {NOP, 12'h000});
        else begin
          chk("cmd", m_cmd, cmd_q[0].cmd);
          chk("addr", m_addr, cmd_q[0].addr);
          if (cmd_q[0].gap >= 0) chk("cmd_gap", cyc - last_cyc, cmd_q[0].gap);
          void'(cmd_q.pop_front());
        end
        last_cyc <= cyc;
      end
      if (m_oe) begin
        if (data_q.size() == 0) chk("unexpected_data", m_data, 16'hxxxx);
        else begin
          chk("data", m_data, data_q[0]);
          void'(data_q.pop_front());
        end
      end
    end
  end

  task automatic push_cmd(input logic [3:0] c, input logic [11:0] a, input int g);
    exp_cmd_t e;
    e.cmd = c; e.addr = a; e.gap = g;
    cmd_q.push_back(e);
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(i);
      mem[wr_ptr] = b;
      data_q.push_back({8'h00, b});
      wr_ptr = wr_ptr + 10'd1;
    end
  endtask

  task automatic pulse_trig(input bit which);
    @(posedge sclk); #1;
    if (which) trig_b = 1'b1; else trig_a = 1'b1;
    @(posedge sclk); #1;
    trig_a = 1'b0; trig_b = 1'b0;
  endtask

  task automatic wait_rden(input int budget);
    int n = 0;
    do begin @(negedge sclk); n++; end while (!m_rden && n < budget);
    if (!m_rden) chk("timeout_rden", 0, 1);
  endtask

  task automatic wait_end(input int target, input int budget);
    int n = 0;
    while (end_cnt < target && n < budget) begin @(negedge sclk); n++; end
    if (end_cnt < target) chk("timeout_end", end_cnt, target);
  endtask

  task automatic job2(input logic [11:0] a0, input logic [7:0] base);
    load(8, base);
    push_cmd(ACT, 12'd0, -1);
    push_cmd(WRC, a0, 4);
    push_cmd(WRC, a0 + 12'd4, 4);
    push_cmd(PRE, 12'h400, 4);
  endtask

  task automatic check_idle(input string tag, input int rd0, input int e0, input int rd_exp);
    repeat (6) @(negedge sclk);
    chk({tag, "_cmdq"}, cmd_q.size(), 0);
    chk({tag, "_dataq"}, data_q.size(), 0);
    chk({tag, "_rden_cycles"}, rd_cnt - rd0, rd_exp);
    chk({tag, "_end_pulses"}, end_cnt - e0, 1);
    chk({tag, "_wr_req"}, m_rden | (sel ? ifb.wr_req : ifa.wr_req), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd0, e0, n;
    reset = 1'b0; sel = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    wr_en = 1'b1; ref_req = 1'b0; wr_ptr = '0;
    repeat (3) @(posedge sclk); #1;
    chk("rst_cmd", ifa.wr_cmd, NOP);
    chk("rst_addr", ifa.wr_addr, 0);
    chk("rst_oe", ifa.wr_dq_oe, 0);
    chk("rst_wr_req", ifa.wr_req, 0);
    chk("rst_rden", ifa.wfifo_rd_en, 0);
    chk("rst_end", ifa.flag_wr_end, 0);
    chk("rst_data", ifa.wr_data, 0);
    chk("bank_addr", ifa.bank_addr, 0);
    @(negedge sclk); reset = 1'b1;

    // basic 2-burst job
    rd0 = rd_cnt; e0 = end_cnt;
    job2(12'd0, 8'h11);
    pulse_trig(0);
    wait_end(e0 + 1, 60);
    check_idle("basic", rd0, e0, 8);

    // refresh request mid-burst: finish burst, release bus, resume
    rd0 = rd_cnt; e0 = end_cnt;
    load(8, 8'h21);
    push_cmd(ACT, 12'd0, -1);
    push_cmd(WRC, 12'd8, 4);
    push_cmd(PRE, 12'h400, 4);
    push_cmd(ACT, 12'd0, -1);
    push_cmd(WRC, 12'd12, 4);
    push_cmd(PRE, 12'h400, 4);
    pulse_trig(0);
    wait_rden(30);
    @(posedge sclk); #1;
    ref_req = 1'b1; wr_en = 1'b0;
    wait_end(e0 + 1, 40);
    chk("ref_wr_req", ifa.wr_req, 1);
    chk("ref_rden", ifa.wfifo_rd_en, 0);
    chk("ref_words", rd_cnt - rd0, 4);
    repeat (3) @(negedge sclk);
    chk("ref_hold_req", ifa.wr_req, 1);
    ref_req = 1'b0; wr_en = 1'b1;
    wait_end(e0 + 2, 60);
    repeat (6) @(negedge sclk);
    chk("ref_cmdq", cmd_q.size(), 0);
    chk("ref_rden_cycles", rd_cnt - rd0, 8);
    chk("ref_end_pulses", end_cnt - e0, 2);

    // wr_trig while busy is ignored
    rd0 = rd_cnt; e0 = end_cnt;
    job2(12'd16, 8'h31);
    pulse_trig(0);
    wait_rden(30);
    pulse_trig(0);
    wait_end(e0 + 1, 80);
    check_idle("busy_trig", rd0, e0, 8);

    // row crossing on the 129-burst controller
    sel = 1'b1;
    rd0 = rd_cnt; e0 = end_cnt;
    load(516, 8'h40);
    push_cmd(ACT, 12'd0, -1);
    for (int c = 0; c < 128; c++) push_cmd(WRC, 12'(c * 4), 4);
    push_cmd(PRE, 12'h400, 4);
    push_cmd(ACT, 12'd1, 4);
    push_cmd(WRC, 12'd0, 4);
    push_cmd(PRE, 12'h400, 4);
    pulse_trig(1);
    n = 0;
    while (rd_cnt - rd0 < 513 && n < 800) begin @(negedge sclk); n++; end
    chk("rc_reach_row1", (rd_cnt - rd0 >= 513), 1);
    chk("rc_no_end_pulse", end_cnt - e0, 0);
    wait_end(e0 + 1, 60);
    check_idle("rowcross", rd0, e0, 516);
    sel = 1'b0;

    // reset mid-burst abandons the job and clears the position
    job2(12'd24, 8'h51);
    pulse_trig(0);
    wait_rden(30);
    @(posedge sclk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_cmd", ifa.wr_cmd, NOP);
    chk("midrst_addr", ifa.wr_addr, 0);
    chk("midrst_oe", ifa.wr_dq_oe, 0);
    chk("midrst_rden", ifa.wfifo_rd_en, 0);
    chk("midrst_wr_req", ifa.wr_req, 0);
    chk("midrst_data", ifa.wr_data, 0);
    cmd_q.delete();
    data_q.delete();
    wr_ptr = rd_ptr;
    @(negedge sclk); reset = 1'b1;
    rd0 = rd_cnt; e0 = end_cnt;
    job2(12'd0, 8'h61);
    pulse_trig(0);
    wait_end(e0 + 1, 60);
    check_idle("after_rst", rd0, e0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
